// File: rtl/circle_plotter.sv
// circle_plotter: midpoint circle rasteriser feeding the VGA adapter's
// pixel-write port. It emits one candidate pixel per clock and clips
// points that fall outside the SCREEN_W x SCREEN_H frame.
//
// Handshake: a draw is requested by a rising edge of the level signal
// `start` while idle. `done` is raised after the last pixel and is held
// until `start` is seen low. Only then can a new rising edge of `start`
// begin another draw. Holding `start` high therefore never causes a redraw.
module circle_plotter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [7:0] radius,
    input  logic [2:0] colour,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_PLOT, S_STEP, S_DONE} state_t;

    state_t             state_q, state_d;
    logic        [7:0]  cx_q, cx_d;
    logic        [6:0]  cy_q, cy_d;
    logic        [7:0]  r_q, r_d;
    logic        [2:0]  col_q, col_d;
    logic signed [10:0] ox_q, ox_d, oy_q, oy_d, crit_q, crit_d;
    logic        [2:0]  oct_q, oct_d;
    logic               start_prev_q, start_prev_d;
    logic               done_q, done_d;
    logic        [7:0]  vga_x_q, vga_x_d;
    logic        [6:0]  vga_y_q, vga_y_d;
    logic        [2:0]  vga_col_q, vga_col_d;
    logic               vga_plot_q, vga_plot_d;

    logic signed [10:0] cx_w, cy_w;
    logic signed [9:0]  cand_x, cand_y;
    logic               in_frame;
    logic signed [10:0] oy_step, ox_step, crit_step;
    logic               start_rise;

    // Candidate point for the current octant, plus the clip test on it.
    always_comb begin
        cx_w = $signed({3'b000, cx_q});
        cy_w = $signed({4'b0000, cy_q});
        cand_x = 10'(cx_w + ox_q);
        cand_y = 10'(cy_w + oy_q);
        case (oct_q)
            3'd0: begin cand_x = 10'(cx_w + ox_q); cand_y = 10'(cy_w + oy_q); end
            3'd1: begin cand_x = 10'(cx_w + oy_q); cand_y = 10'(cy_w + ox_q); end
            3'd2: begin cand_x = 10'(cx_w - ox_q); cand_y = 10'(cy_w + oy_q); end
            3'd3: begin cand_x = 10'(cx_w - oy_q); cand_y = 10'(cy_w + ox_q); end
            3'd4: begin cand_x = 10'(cx_w - ox_q); cand_y = 10'(cy_w - oy_q); end
            3'd5: begin cand_x = 10'(cx_w - oy_q); cand_y = 10'(cy_w - ox_q); end
            3'd6: begin cand_x = 10'(cx_w + ox_q); cand_y = 10'(cy_w - oy_q); end
            default: begin cand_x = 10'(cx_w + oy_q); cand_y = 10'(cy_w - ox_q); end
        endcase
        in_frame = !cand_x[9] && (cand_x < 10'(SCREEN_W)) &&
                   !cand_y[9] && (cand_y < 10'(SCREEN_H));
    end

    // Midpoint decision step: advance oy, maybe pull ox in, update crit.
    always_comb begin
        oy_step = oy_q + 11'sd1;
        if (crit_q <= 11'sd0) begin
            ox_step   = ox_q;
            crit_step = crit_q + (oy_step <<< 1) + 11'sd1;
        end else begin
            ox_step   = ox_q - 11'sd1;
            crit_step = crit_q + ((oy_step - ox_step) <<< 1) + 11'sd1;
        end
    end

    // Next-state and registered-output logic of the draw sequencer.
    always_comb begin
        state_d      = state_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        r_d          = r_q;
        col_d        = col_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        crit_d       = crit_q;
        oct_d        = oct_q;
        start_prev_d = start;
        start_rise   = start && !start_prev_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_col_d    = vga_col_q;
        vga_plot_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    cx_d    = centre_x;
                    cy_d    = centre_y;
                    r_d     = radius;
                    col_d   = colour;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                oy_d    = 11'sd0;
                ox_d    = $signed({3'b000, r_q});
                crit_d  = 11'sd1 - $signed({3'b000, r_q});
                oct_d   = 3'd0;
                state_d = S_PLOT;
            end
            S_PLOT: begin
                vga_x_d    = cand_x[7:0];
                vga_y_d    = cand_y[6:0];
                vga_col_d  = col_q;
                vga_plot_d = in_frame;
                oct_d      = oct_q + 3'd1;
                if (oct_q == 3'd7) state_d = S_STEP;
            end
            S_STEP: begin
                oy_d    = oy_step;
                ox_d    = ox_step;
                crit_d  = crit_step;
                oct_d   = 3'd0;
                state_d = (oy_step <= ox_step) ? S_PLOT : S_DONE;
            end
            S_DONE: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        done_d = (state_d == S_DONE);
    end

    // State and output registers; reset aborts any draw immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cx_q         <= '0;
            cy_q         <= '0;
            r_q          <= '0;
            col_q        <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            crit_q       <= '0;
            oct_q        <= '0;
            start_prev_q <= 1'b0;
            done_q       <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_col_q    <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            r_q          <= r_d;
            col_q        <= col_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            crit_q       <= crit_d;
            oct_q        <= oct_d;
            start_prev_q <= start_prev_d;
            done_q       <= done_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_col_q    <= vga_col_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign done       = done_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_col_q;
    assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_circle_plotter.sv
// Self-checking bench for circle_plotter: directed cases plus random
// draws, each compared cycle by cycle against an integer circle model.
module tb_circle_plotter;

    localparam int W = 160;
    localparam int H = 120;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] radius;
    logic [2:0] colour;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int n_assert = 0;
    int n_fail   = 0;
    int n_pulses;

    // {plot, x[7:0], y[6:0], colour[2:0]} expected per observed cycle
    logic [18:0] exp_q[$];
    bit seen [0:W*H-1];

    circle_plotter #(.SCREEN_W(W), .SCREEN_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .centre_x   (centre_x),
        .centre_y   (centre_y),
        .radius     (radius),
        .colour     (colour),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: the circle as a list of per-cycle expectations. Two idle
    // cycles (start accept, init), then per ring 8 candidates and a gap.
    task automatic build_model(input int cx, input int cy, input int r, input int col);
        int ox, oy, crit, px, py, a, b;
        int sgx [8];
        int sgy [8];
        bit in;
        sgx = '{1, 1, -1, -1, -1, -1, 1, 1};
        sgy = '{1, 1, 1, 1, -1, -1, -1, -1};
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
        ox = r; oy = 0; crit = 1 - r;
        do begin
            for (int k = 0; k < 8; k++) begin
                a = (k % 2 == 1) ? oy : ox;
                b = (k % 2 == 1) ? ox : oy;
                px = cx + sgx[k] * a;
                py = cy + sgy[k] * b;
                in = (px >= 0) && (px < W) && (py >= 0) && (py < H);
                exp_q.push_back({in, 8'(px), 7'(py), 3'(col)});
            end
            exp_q.push_back('0);
            oy = oy + 1;
            if (crit <= 0) crit = crit + 2 * oy + 1;
            else begin
                ox = ox - 1;
                crit = crit + 2 * (oy - ox) + 1;
            end
        end while (oy <= ox);
    endtask

    // Driver + monitor for one full draw; leaves start high at done.
    task automatic run_draw(input int cx, input int cy, input int r, input int col);
        int len;
        logic [18:0] e;
        build_model(cx, cy, r, col);
        len = exp_q.size();
        foreach (seen[i]) seen[i] = 1'b0;
        n_pulses = 0;
        @(negedge clk);
        centre_x = 8'(cx); centre_y = 7'(cy); radius = 8'(r); colour = 3'(col);
        start = 1'b1;
        for (int c = 1; c <= len; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                centre_x = 8'($urandom_range(0, 255));
                centre_y = 7'($urandom_range(0, 127));
                radius   = 8'($urandom_range(0, 255));
                colour   = 3'($urandom_range(0, 7));
            end
            e = exp_q.pop_front();
            check_eq("plot", 32'(vga_plot), 32'(e[18]));
            if (e[18]) begin
                check_eq("x", 32'(vga_x), 32'(e[17:10]));
                check_eq("y", 32'(vga_y), 32'(e[9:3]));
                check_eq("colour", 32'(vga_colour), 32'(e[2:0]));
            end
            if (vga_plot) begin
                n_pulses++;
                if (vga_x < W && vga_y < H) seen[int'(vga_y) * W + int'(vga_x)] = 1'b1;
            end
            check_eq("done", 32'(done), 32'(c == len));
        end
    endtask

    task automatic drop_start();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check_eq("done_fall", 32'(done), 32'd0);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; start = 1'b0;
        centre_x = '0; centre_y = '0; radius = '0; colour = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_plot", 32'(vga_plot), 32'd0);
        check_eq("rst_x", 32'(vga_x), 32'd0);
        check_eq("rst_y", 32'(vga_y), 32'd0);
        check_eq("rst_col", 32'(vga_colour), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Radius 0: eight writes of the centre.
        run_draw(80, 60, 0, 5);
        check_eq("r0_pulses", 32'(n_pulses), 32'd8);
        check_eq("r0_centre", 32'(seen[60 * W + 80]), 32'd1);
        drop_start();

        // Radius 1: two rings, sixteen writes.
        run_draw(80, 60, 1, 3);
        check_eq("r1_pulses", 32'(n_pulses), 32'd16);
        drop_start();

        // Clip at the top-left corner.
        run_draw(0, 0, 10, 2);
        check_eq("clip_10_0", 32'(seen[0 * W + 10]), 32'd1);
        check_eq("clip_0_10", 32'(seen[10 * W + 0]), 32'd1);
        drop_start();

        // Clip at the bottom-right corner.
        run_draw(159, 119, 5, 7);
        check_eq("edge_154_119", 32'(seen[119 * W + 154]), 32'd1);
        check_eq("edge_159_114", 32'(seen[114 * W + 159]), 32'd1);
        drop_start();

        // Random draws anywhere in the input range.
        for (int i = 0; i < 8; i++) begin
            run_draw($urandom_range(0, 255), $urandom_range(0, 127),
                     $urandom_range(0, 50), $urandom_range(0, 7));
            drop_start();
        end

        // Reset in the middle of a large draw.
        @(negedge clk);
        centre_x = 8'd80; centre_y = 7'd60; radius = 8'd40; colour = 3'd4;
        start = 1'b1;
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_plot", 32'(vga_plot), 32'd0);
        check_eq("arst_x", 32'(vga_x), 32'd0);
        check_eq("arst_y", 32'(vga_y), 32'd0);
        check_eq("arst_col", 32'(vga_colour), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (vga_plot) bad++;
        end
        check_eq("arst_quiet", 32'(bad), 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        run_draw(80, 60, 40, 4);
        drop_start();

        // start held high: one draw, done holds, no redraw.
        run_draw(40, 30, 2, 6);
        bad = 0;
        repeat (2000) begin
            @(posedge clk); #1;
            if (!done || vga_plot) bad++;
        end
        check_eq("held_start", 32'(bad), 32'd0);
        drop_start();
        run_draw(40, 30, 2, 6);
        drop_start();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/circle_plotter.md
# circle_plotter

Midpoint (Bresenham) circle rasteriser that drives the pixel-write port of the VGA adapter. It accepts a centre, radius and colour, emits one candidate pixel per clock on a registered x/y/colour/plot bus and clips points that fall off the 160×120 frame. It is the drawing stage directly upstream of the adapter's video memory. The Reuleaux-triangle top level instantiates it and sequences three arcs through it.

## Interface
Parameters:
- SCREEN_W, 160, frame width in pixels; valid x is 0..SCREEN_W-1
- SCREEN_H, 120, frame height in pixels; valid y is 0..SCREEN_H-1

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**
- start  in  1  level request; a draw begins on a rising-edge-detected high level in IDLE
- centre_x  in  8  centre x (unsigned)
- centre_y  in  7  centre y (unsigned)
- radius  in  8  radius (unsigned)
- colour  in  3  pixel colour
- done  out  1  drawing complete; held until start is low
- vga_x  out  8  pixel x to adapter
- vga_y  out  7  pixel y to adapter
- vga_colour  out  3  pixel colour to adapter
- vga_plot  out  1  write strobe, one cycle per written pixel

## Operation
- States: IDLE, INIT, PLOT, STEP, DONE.
- IDLE: wait for start high. On start, latch centre_x, centre_y, radius and colour, then go to INIT.
- INIT: set oy=0, ox=radius and crit=1−radius, then go to PLOT with oct=0.
- PLOT: oct counts 0..7, one cycle each. The candidate point for each oct value is:
  - 0: (cx+ox, cy+oy)
  - 1: (cx+oy, cy+ox)
  - 2: (cx−ox, cy+oy)
  - 3: (cx−oy, cy+ox)
  - 4: (cx−ox, cy−oy)
  - 5: (cx−oy, cy−ox)
  - 6: (cx+ox, cy−oy)
  - 7: (cx+oy, cy−ox)
  - After oct=7, go to STEP.
- STEP: oy←oy+1.
  - If crit≤0: crit←crit+2·oy_new+1.
  - Otherwise: ox←ox−1 and crit←crit+2·(oy_new−ox_new)+1.
  - Then, if oy_new≤ox_new, return to PLOT with oct=0; otherwise go to DONE.
- DONE: assert done. When start goes low, return to IDLE.
- Arithmetic:
  - ox, oy and crit are 11-bit signed.
  - Candidate coordinates are computed in 10-bit signed.
  - Clip: plot only if 0≤x<SCREEN_W and 0≤y<SCREEN_H. Otherwise vga_plot=0 for that cycle, but the cycle is still consumed.
- Duplicate points (octant overlaps, radius 0) are written again, not suppressed.
- Inputs that change after start is accepted are ignored until the next draw.
- If start is held high through DONE, no redraw occurs. start must drop and rise again.

## Timing
- Reset values: done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0; state=IDLE.
- Reset asserted mid-draw aborts immediately. No further plot pulses occur after rst_n falls.
- Outputs are registered. The pixel for PLOT cycle k appears on vga_* in cycle k+1.
- Each midpoint iteration takes 9 cycles: 8 PLOT plus 1 STEP. vga_plot is 0 during STEP, INIT, IDLE and DONE.
- Latency: start sampled high → INIT next cycle → first vga_plot 2 cycles after INIT.
- done rises the cycle after the final STEP and falls the cycle after start is sampled low.

## Test plan
- **Radius 0:** centre (80,60), colour 5.
  - Exactly 8 plot pulses, all at (80,60) with colour 5.
  - One iteration; done follows 1 STEP later.
- **Radius 1:** centre (80,60).
  - Iteration 1, in order: (81,60),(80,61),(79,60),(80,61),(79,60),(80,59),(81,60),(80,59).
  - Iteration 2: (81,61),(81,61),(79,61),(79,61),(79,59),(79,59),(81,59),(81,59).
  - 16 plot pulses total, then done.
- **Clipping:** centre (0,0), radius 10.
  - Every plot pulse has x≥0 and y≥0.
  - Points (10,0) and (0,10) are written.
  - No pulse occurs for negative candidates, yet the total draw length in cycles equals that of an unclipped r=10 draw.
- **Right/bottom edge:** centre (159,119), radius 5.
  - No pulse has x≥160 or y≥120.
  - (154,119) and (159,114) are written.
- **Reset mid-draw:** rst_n low during PLOT of a r=40 draw.
  - All outputs go to 0 asynchronously.
  - After release, a new start draws a complete circle from INIT.
- **Start handshake:** start held high for 2000 cycles with r=2.
  - One draw only; done stays high.
  - Dropping start clears done; re-raising start repeats the identical pixel sequence.
